// File: rtl/sfifo_stream_reader.sv
// Read-side controller for the FFT synchronous FIFO: turns rd_cs/rd_en pops with 1-cycle read latency
// into a valid/ready stream. Optional frame counter enabled by defining FIFO_RD_FRAME_EN.
module sfifo_stream_reader #(
    parameter int DATA_W    = 32,
    parameter int FRAME_LEN = 64,
    parameter int FRAME_W   = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              fifo_rd_cs,
    output logic              fifo_rd_en,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              out_last,
    output logic [FRAME_W-1:0] frame_idx
);

    if ((1 << FRAME_W) < FRAME_LEN) begin : g_bad_frame_w
        $error("FRAME_W too narrow for FRAME_LEN");
    end

    // Handshake: a word moves downstream on every cycle where out_valid && out_ready;
    // out_valid is purely registered and never looks at out_ready.
    logic [DATA_W-1:0] head_q, tail_q, head_d, tail_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              infl_q;
    logic              run_q;
    logic              pop;
    logic [2:0]        occupancy;

    assign out_valid  = (cnt_q != 2'd0);
    assign out_data   = head_q;
    assign pop        = out_valid && out_ready;

    // Words already owned by the reader (buffered + in flight) after this cycle's pop.
    assign occupancy  = {1'b0, cnt_q} + {2'b00, infl_q} - {2'b00, pop};
    assign fifo_rd_en = run_q && enable && !fifo_empty && (occupancy < 3'd2);
    assign fifo_rd_cs = fifo_rd_en;

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        unique case ({infl_q, pop})
            2'b10: begin
                if (cnt_q == 2'd0) head_d = fifo_data;
                else               tail_d = fifo_data;
                cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
                head_d = tail_q;
                cnt_d  = cnt_q - 2'd1;
            end
            2'b11: begin
                // Capture and pop together: occupancy stays put, order is preserved.
                if (cnt_q == 2'd2) begin
                    head_d = tail_q;
                    tail_d = fifo_data;
                end else begin
                    head_d = fifo_data;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= 2'd0;
            infl_q <= 1'b0;
            run_q  <= 1'b0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
            infl_q <= fifo_rd_en;
            run_q  <= 1'b1;
        end
    end

`ifdef FIFO_RD_FRAME_EN
    localparam logic [FRAME_W-1:0] LAST_IDX = FRAME_W'(FRAME_LEN - 1);
    logic [FRAME_W-1:0] frame_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_q <= '0;
        end else if (pop) begin
            frame_q <= (frame_q == LAST_IDX) ? '0 : frame_q + 1'b1;
        end
    end

    assign frame_idx = frame_q;
    assign out_last  = out_valid && (frame_q == LAST_IDX);
`else
    assign frame_idx = '0;
    assign out_last  = 1'b0;
`endif

endmodule

// File: tb/tb_sfifo_stream_reader.sv
// Bench for sfifo_stream_reader: FIFO model, stream model (read-cycle + word queues) checked every
// cycle, and directed scenarios with literal expectations. Frame checks follow FIFO_RD_FRAME_EN.
module tb_sfifo_stream_reader;
    localparam int DW = 32;
    localparam int FL = 4;
    localparam int FW = 6;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic          fifo_empty = 1'b1;
    logic [DW-1:0] fifo_data = '0;
    logic          fifo_rd_cs, fifo_rd_en, out_valid, out_last;
    logic [DW-1:0] out_data;
    logic          out_ready = 1'b0;
    logic [FW-1:0] frame_idx;

    sfifo_stream_reader #(.DATA_W(DW), .FRAME_LEN(FL), .FRAME_W(FW)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .fifo_empty(fifo_empty),
        .fifo_data(fifo_data), .fifo_rd_cs(fifo_rd_cs), .fifo_rd_en(fifo_rd_en),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .out_last(out_last), .frame_idx(frame_idx)
    );

    always #5 clk = ~clk;

    int tot = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tot++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Synchronous FIFO model: registered data_out, loads absorbed at a clock edge.
    logic [DW-1:0] fq[$];
    logic [DW-1:0] load_q[$];
    always @(posedge clk) begin
        if (!rst_n) begin
            fq.delete();
            load_q.delete();
            fifo_data <= '0;
        end else begin
            if (fifo_rd_en && fq.size() > 0) fifo_data <= fq.pop_front();
            while (load_q.size() > 0) fq.push_back(load_q.pop_front());
        end
        fifo_empty <= (fq.size() == 0);
    end

    // Stream model: every read issued at cycle c must be presented from cycle c+2, in load order.
    logic [DW-1:0] exp_q[$];
    int rd_cyc_q[$];
    int cyc = 0;
    int pops = 0;
    int rd_count, pop_count, first_rd, last_rd, first_valid;
    int log_idx[$];
    int log_last[$];

    always @(negedge clk) begin
        logic ev, ep, er;
        int held, eidx;
        logic elast;
        if (!rst_n) begin
            rd_cyc_q.delete();
            pops = 0;
        end else begin
            cyc++;
            held = rd_cyc_q.size();
            ev = (held > 0) && (rd_cyc_q[0] + 2 <= cyc);
            ep = ev && out_ready;
            er = enable && !fifo_empty && ((held - int'(ep)) < 2);
`ifdef FIFO_RD_FRAME_EN
            eidx  = pops % FL;
            elast = (eidx == FL - 1);
`else
            eidx  = 0;
            elast = 1'b0;
`endif
            chk("rd_en", fifo_rd_en, er);
            chk("rd_cs", fifo_rd_cs, er);
            chk("out_valid", out_valid, ev);
            if (ev) begin
                chk("out_data", out_data, (exp_q.size() > 0) ? exp_q[0] : 32'hdead_beef);
                chk("frame_idx", frame_idx, eidx);
                chk("out_last", out_last, elast);
            end
            if (fifo_rd_en) begin
                rd_count++;
                if (first_rd < 0) first_rd = cyc;
                last_rd = cyc;
                rd_cyc_q.push_back(cyc);
            end
            if (out_valid && first_valid < 0) first_valid = cyc;
            if (ep) begin
                void'(rd_cyc_q.pop_front());
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                pops++;
                pop_count++;
                log_idx.push_back(int'(frame_idx));
                log_last.push_back(int'(out_last));
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic clear_stats();
        rd_count = 0; pop_count = 0;
        first_rd = -1; last_rd = -1; first_valid = -1;
        log_idx.delete(); log_last.delete();
    endtask

    task automatic do_reset();
        enable = 1'b0;
        out_ready = 1'b0;
        rst_n = 1'b0;
        exp_q.delete();
        step(2);
        rst_n = 1'b1;
        step(1);
        clear_stats();
    endtask

    task automatic load(input int n, input logic [DW-1:0] base);
        for (int i = 0; i < n; i++) begin
            load_q.push_back(base + DW'(i));
            exp_q.push_back(base + DW'(i));
        end
        step(1);
    endtask

    task automatic wait_pops(input int n, input int budget, input string name);
        int k = 0;
        while (pop_count < n && k < budget) begin
            step(1);
            k++;
        end
        chk(name, pop_count, n);
    endtask

    task automatic frame_run(input bit random_ready);
        int exp_idx_tab[10] = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1};
        int k = 0;
        do_reset();
        load(10, 32'h40);
        enable = 1'b1;
        while (pop_count < 10 && k < 200) begin
            out_ready = random_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            step(1);
            k++;
        end
        chk("frame_pops", pop_count, 10);
        chk("frame_log_len", log_idx.size(), 10);
        for (int i = 0; i < 10 && i < log_idx.size(); i++) begin
`ifdef FIFO_RD_FRAME_EN
            chk($sformatf("frame_idx_%0d", i), log_idx[i], exp_idx_tab[i]);
            chk($sformatf("out_last_%0d", i), log_last[i], (i == 3 || i == 7) ? 1 : 0);
`else
            chk($sformatf("frame_idx_%0d", i), log_idx[i], 0);
            chk($sformatf("out_last_%0d", i), log_last[i], 0);
`endif
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_stats();
        // Reset mid-operation with the FIFO still holding data and enable high.
        do_reset();
        load(4, 32'h10);
        enable = 1'b1;
        step(4);
        rst_n = 1'b0;
        #1;
        chk("rst_fifo_nonempty", fifo_empty, 0);
        chk("rst_rd_en", fifo_rd_en, 0);
        chk("rst_rd_cs", fifo_rd_cs, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_frame_idx", frame_idx, 0);

        // Continuous stream of 8 words.
        do_reset();
        load(8, 32'h10);
        out_ready = 1'b1;
        enable = 1'b1;
        wait_pops(8, 30, "stream_pops");
        step(3);
        chk("stream_reads", rd_count, 8);
        chk("stream_rd_span", last_rd - first_rd, 7);
        chk("stream_latency", first_valid - first_rd, 2);

        // Backpressure: only two words may be pulled while ready is low.
        do_reset();
        load(4, 32'h10);
        enable = 1'b1;
        step(6);
        chk("bp_reads", rd_count, 2);
        chk("bp_valid", out_valid, 1);
        chk("bp_data", out_data, 32'h10);
        out_ready = 1'b1;
        wait_pops(4, 20, "bp_pops");
        chk("bp_reads_total", rd_count, 4);

        // Single word: one pulse, nothing more once empty.
        do_reset();
        load(1, 32'h55);
        out_ready = 1'b1;
        enable = 1'b1;
        step(6);
        chk("one_reads", rd_count, 1);
        chk("one_pops", pop_count, 1);
        chk("one_empty", fifo_empty, 1);

        // enable drop after three reads.
        do_reset();
        load(8, 32'h20);
        out_ready = 1'b1;
        enable = 1'b1;
        step(3);
        enable = 1'b0;
        step(8);
        chk("en_drop_reads", rd_count, 3);
        chk("en_drop_pops", pop_count, 3);
        enable = 1'b1;
        wait_pops(8, 30, "en_resume_pops");
        chk("en_resume_reads", rd_count, 8);

        // Frame indexing with steady and random ready.
        frame_run(1'b0);
        frame_run(1'b1);

        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end
endmodule
